// File: rtl/usbf_csr_arb.sv
// Round-robin arbiter/sequencer sharing the single USB CSR port between the host
// bus unit (m0) and the descriptor/DMA engine (m1); one access in flight at a time.
module usbf_csr_arb #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        hclk_i,
  input  logic        hrst_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  input  logic        m0_req_write_i,
  input  logic [31:0] m0_req_addr_i,
  input  logic [31:0] m0_req_wdata_i,
  output logic        m0_rsp_valid_o,
  input  logic        m0_rsp_ready_i,
  output logic [31:0] m0_rsp_rdata_o,
  output logic        m0_rsp_err_o,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  input  logic        m1_req_write_i,
  input  logic [31:0] m1_req_addr_i,
  input  logic [31:0] m1_req_wdata_i,
  output logic        m1_rsp_valid_o,
  input  logic        m1_rsp_ready_i,
  output logic [31:0] m1_rsp_rdata_o,
  output logic        m1_rsp_err_o,
  output logic        wt_en_o,
  output logic        rd_en_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        wt_ready_i,
  input  logic        rd_ready_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic             last_grant, grant;
  logic             write_q, err_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0] cnt;

  logic win, accept, completion, timeout_hit, rsp_taken;

  // Both requesting: favour whoever was not served last
  always_comb begin
    win = 1'b0;
    if (m0_req_valid_i && m1_req_valid_i) win = ~last_grant;
    else if (m1_req_valid_i)               win = 1'b1;
  end

  assign accept      = (state == IDLE) && (m0_req_valid_i || m1_req_valid_i);
  assign completion  = write_q ? wt_ready_i : rd_ready_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_CNT);
  assign rsp_taken   = grant ? m1_rsp_ready_i : m0_rsp_ready_i;

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (completion || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          grant   <= win;
          write_q <= win ? m1_req_write_i : m0_req_write_i;
          addr_q  <= win ? m1_req_addr_i  : m0_req_addr_i;
          wdata_q <= win ? m1_req_wdata_i : m0_req_wdata_i;
        end
        ACCESS: cnt <= '0;
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          // A completion arriving on the timeout cycle still counts as success
          if (completion) begin
            err_q   <= 1'b0;
            rdata_q <= write_q ? 32'h0 : rdata_i;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        RESP: if (rsp_taken) begin
          last_grant <= grant;
          err_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m0_req_ready_o = accept && !win;
  assign m1_req_ready_o = accept && win;

  assign m0_rsp_valid_o = (state == RESP) && !grant;
  assign m1_rsp_valid_o = (state == RESP) && grant;
  assign m0_rsp_rdata_o = m0_rsp_valid_o ? rdata_q : 32'h0;
  assign m1_rsp_rdata_o = m1_rsp_valid_o ? rdata_q : 32'h0;
  assign m0_rsp_err_o   = m0_rsp_valid_o && err_q;
  assign m1_rsp_err_o   = m1_rsp_valid_o && err_q;

  assign wt_en_o = (state == ACCESS) && write_q;
  assign rd_en_o = (state == ACCESS) && !write_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_usbf_csr_arb.sv
// Self-checking bench for usbf_csr_arb: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_usbf_csr_arb;

  localparam int TO = 4;

  logic        hclk_i = 1'b0;
  logic        hrst_i;
  logic        m0_req_valid_i, m0_req_ready_o, m0_req_write_i;
  logic [31:0] m0_req_addr_i, m0_req_wdata_i, m0_rsp_rdata_o;
  logic        m0_rsp_valid_o, m0_rsp_ready_i, m0_rsp_err_o;
  logic        m1_req_valid_i, m1_req_ready_o, m1_req_write_i;
  logic [31:0] m1_req_addr_i, m1_req_wdata_i, m1_rsp_rdata_o;
  logic        m1_rsp_valid_o, m1_rsp_ready_i, m1_rsp_err_o;
  logic        wt_en_o, rd_en_o, wt_ready_i, rd_ready_i, busy_o;
  logic [31:0] addr_o, wdata_o, rdata_i;

  usbf_csr_arb #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .hclk_i(hclk_i), .hrst_i(hrst_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_req_write_i(m0_req_write_i), .m0_req_addr_i(m0_req_addr_i),
    .m0_req_wdata_i(m0_req_wdata_i), .m0_rsp_valid_o(m0_rsp_valid_o),
    .m0_rsp_ready_i(m0_rsp_ready_i), .m0_rsp_rdata_o(m0_rsp_rdata_o),
    .m0_rsp_err_o(m0_rsp_err_o),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_req_write_i(m1_req_write_i), .m1_req_addr_i(m1_req_addr_i),
    .m1_req_wdata_i(m1_req_wdata_i), .m1_rsp_valid_o(m1_rsp_valid_o),
    .m1_rsp_ready_i(m1_rsp_ready_i), .m1_rsp_rdata_o(m1_rsp_rdata_o),
    .m1_rsp_err_o(m1_rsp_err_o),
    .wt_en_o(wt_en_o), .rd_en_o(rd_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .wt_ready_i(wt_ready_i), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o)
  );

  always #5 hclk_i = ~hclk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        model_last;
  logic [31:0] model_addr, model_wdata;
  int          grant_log[$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic v0, input logic v1, input logic w0, input logic w1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1);
    m0_req_valid_i = v0; m0_req_write_i = w0; m0_req_addr_i = a0; m0_req_wdata_i = d0;
    m1_req_valid_i = v1; m1_req_write_i = w1; m1_req_addr_i = a1; m1_req_wdata_i = d1;
  endtask

  // One full transaction: grant, strobe, completion or timeout, response handshake.
  // cmpl_at = WAIT-cycle index of the completion pulse, -1 for none.
  task automatic run_txn(input logic v0, input logic v1, input logic w0, input logic w1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int cmpl_at, input logic [31:0] rdv, input int hold,
                         input bit keep, input bit stray, input string tag);
    int          g;
    logic        wr, exp_err, done;
    logic [31:0] ad, wd, exp_rd;
    g  = (v0 && v1) ? (model_last ? 0 : 1) : (v0 ? 0 : 1);
    wr = g ? w1 : w0;
    ad = g ? a1 : a0;
    wd = g ? d1 : d0;
    exp_err = !(cmpl_at >= 0 && cmpl_at <= TO);
    exp_rd  = (!exp_err && !wr) ? rdv : 32'h0;

    apply_stimulus(v0, v1, w0, w1, a0, a1, d0, d1);
    #1;
    check_output({tag, ".t0_busy"}, busy_o, 1'b0);
    check_output({tag, ".t0_addr_hold"}, addr_o, model_addr);
    check_output({tag, ".t0_wdata_hold"}, wdata_o, model_wdata);
    check_output({tag, ".t0_ready0"}, m0_req_ready_o, g == 0);
    check_output({tag, ".t0_ready1"}, m1_req_ready_o, g == 1);
    check_output({tag, ".t0_rspv"}, {m0_rsp_valid_o, m1_rsp_valid_o}, 2'b00);
    tick;
    if (!keep) begin m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0; end
    #1;
    check_output({tag, ".t1_wt_en"}, wt_en_o, wr);
    check_output({tag, ".t1_rd_en"}, rd_en_o, !wr);
    check_output({tag, ".t1_addr"}, addr_o, ad);
    check_output({tag, ".t1_wdata"}, wdata_o, wd);
    check_output({tag, ".t1_busy"}, busy_o, 1'b1);
    check_output({tag, ".t1_ready"}, {m0_req_ready_o, m1_req_ready_o}, 2'b00);
    model_addr  = ad;
    model_wdata = wd;

    done = 1'b0;
    for (int k = 0; !done && k <= TO; k++) begin
      tick;
      wt_ready_i = 1'b0; rd_ready_i = 1'b0; rdata_i = $urandom;
      if (k == cmpl_at) begin
        if (wr) wt_ready_i = 1'b1;
        else begin rd_ready_i = 1'b1; rdata_i = rdv; end
      end else if (stray) begin
        if (wr) rd_ready_i = 1'b1;
        else    wt_ready_i = 1'b1;
      end
      #1;
      check_output($sformatf("%s.w%0d_strobes", tag, k), {wt_en_o, rd_en_o}, 2'b00);
      check_output($sformatf("%s.w%0d_addr", tag, k), addr_o, ad);
      check_output($sformatf("%s.w%0d_busy_rspv", tag, k),
                   {busy_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_req_ready_o, m1_req_ready_o}, 5'b10000);
      done = (k == cmpl_at) || (k == TO);
    end

    for (int h = 0; h <= hold; h++) begin
      tick;
      wt_ready_i = stray; rd_ready_i = stray; rdata_i = $urandom;
      m0_rsp_ready_i = (g == 0) && (h == hold);
      m1_rsp_ready_i = (g == 1) && (h == hold);
      #1;
      check_output($sformatf("%s.r%0d_valid", tag, h), {m0_rsp_valid_o, m1_rsp_valid_o}, g ? 2'b01 : 2'b10);
      check_output($sformatf("%s.r%0d_rdata", tag, h), g ? m1_rsp_rdata_o : m0_rsp_rdata_o, exp_rd);
      check_output($sformatf("%s.r%0d_err", tag, h), g ? m1_rsp_err_o : m0_rsp_err_o, exp_err);
      check_output($sformatf("%s.r%0d_other", tag, h),
                   {g ? m0_rsp_rdata_o : m1_rsp_rdata_o}, 32'h0);
      check_output($sformatf("%s.r%0d_ready", tag, h), {m0_req_ready_o, m1_req_ready_o}, 2'b00);
    end
    tick;
    wt_ready_i = 1'b0; rd_ready_i = 1'b0;
    m0_rsp_ready_i = 1'b0; m1_rsp_ready_i = 1'b0;
    model_last = g[0];
    grant_log.push_back(g);
  endtask

  initial begin
    hrst_i = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    m0_rsp_ready_i = 0; m1_rsp_ready_i = 0;
    wt_ready_i = 0; rd_ready_i = 0; rdata_i = 0;
    model_last = 1'b1; model_addr = 0; model_wdata = 0;
    tick; tick;
    check_output("rst_outputs", {busy_o, wt_en_o, rd_en_o, m0_rsp_valid_o, m1_rsp_valid_o}, 5'b0);
    check_output("rst_addr", addr_o, 32'h0);
    hrst_i = 1'b0;
    tick;

    $display("[TB] write from m0, completion on first WAIT cycle");
    run_txn(1, 0, 1, 0, 32'h1000_0010, 0, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, "t1_wr");

    $display("[TB] read from m1, delayed completion, response held");
    run_txn(0, 1, 0, 0, 0, 32'h1000_0020, 0, 0, 3, 32'h1234_5678, 3, 0, 0, "t2_rd");

    $display("[TB] continuous contention");
    grant_log.delete();
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, i[0], !i[0], 32'h2000_0000 + i, 32'h3000_0000 + i,
              32'hD0 + i, 32'hD1 + i, 1, 32'hCAFE_0000 + i, 0, 1, 0, $sformatf("t3_rr%0d", i));
    m0_req_valid_i = 0; m1_req_valid_i = 0;
    for (int i = 0; i < 4; i++)
      check_output($sformatf("t3_order%0d", i), grant_log[i], (i % 2 == 0) ? 0 : 1);

    $display("[TB] timeout, then completion on the timeout cycle");
    run_txn(1, 0, 0, 0, 32'h4000_0004, 0, 0, 0, -1, 32'hDEAD_BEEF, 1, 0, 0, "t4_to");
    run_txn(1, 0, 0, 0, 32'h4000_0008, 0, 0, 0, TO, 32'h0BAD_F00D, 0, 0, 0, "t4_edge");

    $display("[TB] stray completion pulses");
    rd_ready_i = 1; wt_ready_i = 1; rdata_i = 32'hFFFF_FFFF;
    #1 check_output("t5_idle_stray", busy_o, 1'b0);
    tick;
    rd_ready_i = 0; wt_ready_i = 0;
    #1 check_output("t5_idle_after", busy_o, 1'b0);
    run_txn(0, 1, 0, 0, 0, 32'h5000_0050, 0, 0, 2, 32'h5555_AAAA, 1, 0, 1, "t5_rd");

    $display("[TB] reset during WAIT");
    apply_stimulus(1, 0, 0, 0, 32'h6000_0060, 0, 32'h66, 0);
    tick; m0_req_valid_i = 0;
    tick; tick;
    #2 hrst_i = 1'b1;
    #1;
    check_output("t6_rst_ctrl",
                 {busy_o, wt_en_o, rd_en_o, m0_rsp_valid_o, m1_rsp_valid_o, m0_req_ready_o, m1_req_ready_o}, 7'b0);
    check_output("t6_rst_addr", addr_o, 32'h0);
    check_output("t6_rst_wdata", wdata_o, 32'h0);
    tick;
    hrst_i = 1'b0;
    model_last = 1'b1; model_addr = 0; model_wdata = 0;
    tick;
    grant_log.delete();
    run_txn(1, 1, 1, 1, 32'h7000_0070, 32'h7100_0071, 32'h77, 32'h71, 0, 0, 0, 0, 0, "t6_first");
    check_output("t6_first_grant", grant_log[0], 0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      logic [1:0] pat;
      int         r;
      pat = 2'($urandom_range(1, 3));
      r   = $urandom_range(0, 7);
      run_txn(pat[0], pat[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
              (r == 7) ? -1 : r, $urandom, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
